// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial add/subtract engine.
// Provides the FSM state encoding and the mode constants.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit combinational full adder used by the serial engine.
// Ports: a, b, cin -> s (sum), c (carry out).
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial WIDTH-bit add/subtract engine, LSB first, one full-adder cell.
// Ports: clk, reset (async active-low), start/mode/a/b in;
//   busy, done, result {cout,sum}, overflow, bit_count out.
// Macro SERIAL_ADDSUB_PRESCALE_EN: step once every CLK_DIV clocks.
module serial_addsub_unit
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 5_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH:0]             result,
  output logic                       overflow,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-2:0] sum_sr;
  logic             carry;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             step_en;
  logic [WIDTH-1:0] sum_nx;

  assign accept = start && (state != SHIFT);
  assign sum_nx = {fa_s, sum_sr};

  serial_fa_cell u_fa (
    .a   (reg_a[0]),
    .b   (reg_b[0]),
    .cin (carry),
    .s   (fa_s),
    .c   (fa_c)
  );

`ifdef SERIAL_ADDSUB_PRESCALE_EN
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] pre;

  // Clock enable only: the engine never runs on a derived clock.
  assign step_en = (state == SHIFT) && (pre == PMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (accept) begin
      pre <= '0;
    end else if (state == SHIFT) begin
      pre <= step_en ? '0 : pre + 1'b1;
    end
  end
`else
  logic unused_div;
  assign unused_div = (CLK_DIV != 0);
  assign step_en = (state == SHIFT);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      reg_a     <= '0;
      reg_b     <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      bit_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
    end else if (accept) begin
      state     <= SHIFT;
      reg_a     <= a;
      // Subtract as a + ~b + 1: the +1 rides in on the initial carry.
      reg_b     <= (mode == MODE_SUB) ? ~b : b;
      carry     <= (mode == MODE_SUB);
      bit_count <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else if (step_en) begin
      reg_a     <= reg_a >> 1;
      reg_b     <= reg_b >> 1;
      sum_sr    <= sum_nx[WIDTH-1:1];
      carry     <= fa_c;
      bit_count <= bit_count + 1'b1;
      if (bit_count == LAST) begin
        result   <= {fa_c, fa_s, sum_sr};
        // Signed overflow: carry into MSB differs from carry out.
        overflow <= carry ^ fa_c;
        done     <= 1'b1;
        busy     <= 1'b0;
        state    <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed scoreboard bench for serial_addsub_unit, WIDTH=8.
// Expected results are queued at start and checked when done rises.
module tb_serial_addsub_unit;

  localparam int W = 8;

  typedef struct packed {
    logic [W:0] res;
    logic       ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W:0]   result;
  logic         overflow;
  logic [3:0]   bit_count;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_addsub_unit #(.WIDTH(W), .CLK_DIV(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .bit_count (bit_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic m,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    logic [W:0] r;
    if (m) begin
      r = {1'b0, x} + {1'b0, ~y} + 9'd1;
      e.ovf = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r = {1'b0, x} + {1'b0, y};
      e.ovf = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
    e.res = r;
    return e;
  endfunction

  // inj: posedges after accept at which a stray start is pulsed (0 = none)
  task automatic run_op(input string tag,
                        input logic m,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        input int inj);
    int n;
    exp_t e;
    start = 1'b1;
    mode  = m;
    a     = x;
    b     = y;
    sb.push_back(model(m, x, y));
    @(negedge clk);
    start = 1'b0;
    n = 0;
    check({tag, " busy@accept"}, 32'(busy), 32'd1);
    check({tag, " done@accept"}, 32'(done), 32'd0);
    while (!done && n < 40) begin
      if (inj != 0 && n == inj) begin
        start = 1'b1;
        mode  = ~m;
        a     = ~x;
        b     = x;
      end
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n < W) check({tag, " busy"}, 32'(busy), 32'd1);
    end
    check({tag, " latency"}, 32'(n), 32'(W));
    check({tag, " busy@done"}, 32'(busy), 32'd0);
    check({tag, " bit_count"}, 32'(bit_count), 32'(W));
    check({tag, " sb_size"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, " result"}, 32'(result), 32'(e.res));
      check({tag, " overflow"}, 32'(overflow), 32'(e.ovf));
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst ovf", 32'(overflow), 32'd0);
    check("rst cnt", 32'(bit_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op("add200+100", 1'b0, 8'd200, 8'd100, 0);
    check("add200+100 const", 32'(result), 32'h12C);
    run_op("add127+1", 1'b0, 8'd127, 8'd1, 0);
    check("add127+1 const", 32'({result, overflow}), 32'({9'h080, 1'b1}));
    run_op("sub9-5", 1'b1, 8'd9, 8'd5, 0);
    check("sub9-5 const", 32'({result, overflow}), 32'({9'h104, 1'b0}));
    run_op("sub5-9", 1'b1, 8'd5, 8'd9, 0);
    check("sub5-9 const", 32'({result, overflow}), 32'({9'h0FC, 1'b0}));
    run_op("sub128-1", 1'b1, 8'd128, 8'd1, 0);
    check("sub128-1 const", 32'({result, overflow}), 32'({9'h17F, 1'b1}));

    run_op("ignore_start", 1'b0, 8'd55, 8'd66, 3);
    check("ignore_start const", 32'(result), 32'd121);
    @(negedge clk);
    @(negedge clk);
    check("done held", 32'(done), 32'd1);
    run_op("restart", 1'b1, 8'd3, 8'd200, 0);
    run_op("add255+255", 1'b0, 8'd255, 8'd255, 0);

    start = 1'b1;
    mode  = 1'b0;
    a     = 8'd77;
    b     = 8'd88;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", 32'(result), 32'd0);
    check("abort ovf", 32'(overflow), 32'd0);
    check("abort cnt", 32'(bit_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);
    check("idle done", 32'(done), 32'd0);
    run_op("post_reset", 1'b1, 8'd100, 8'd27, 0);
    run_op("rand", 1'b0, 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
